uart_rx_frame_check: RTL

UART_RX_FRAME_CHECK -- requirements
Module: uart_rx_frame_check

---
 rtl/uart_rx_frame_check.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/uart_rx_frame_check.sv
// UART receive frame checker: assembles the data bits from voted bit samples and
// flags start, parity and stop errors per frame. It also keeps saturating error totals.
module uart_rx_frame_check #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  frame_start,
    input  logic                  sample_valid,
    input  logic                  sampled_bit,
    input  logic                  par_en,
    input  logic                  par_odd,
    input  logic                  two_stop,
    input  logic                  clr_cnt,
    output logic                  busy,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  start_err,
    output logic                  par_err,
    output logic                  stop_err,
    output logic [CNT_WIDTH-1:0]  start_err_cnt,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt
);

    localparam int unsigned IDX_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                  state;
    logic [IDX_W-1:0]        idx;
    logic [DATA_WIDTH-1:0]   data_sh;
    logic                    acc;
    logic                    stop_idx;
    logic                    start_bad;
    logic                    par_bad;
    logic                    stop_bad;
    logic                    par_en_q;
    logic                    par_odd_q;
    logic                    two_stop_q;

    // Frame FSM; frame_start restarts from any state and wins over a coincident sample.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            idx        <= '0;
            data_sh    <= '0;
            acc        <= 1'b0;
            stop_idx   <= 1'b0;
            start_bad  <= 1'b0;
            par_bad    <= 1'b0;
            stop_bad   <= 1'b0;
            par_en_q   <= 1'b0;
            par_odd_q  <= 1'b0;
            two_stop_q <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            data_out   <= '0;
            start_err  <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            start_err  <= 1'b0;
            par_err    <= 1'b0;
            stop_err   <= 1'b0;
            if (frame_start) begin
                state      <= START;
                busy       <= 1'b1;
                par_en_q   <= par_en;
                par_odd_q  <= par_odd;
                two_stop_q <= two_stop;
                idx        <= '0;
                acc        <= 1'b0;
                stop_idx   <= 1'b0;
                start_bad  <= 1'b0;
                par_bad    <= 1'b0;
                stop_bad   <= 1'b0;
            end else if (sample_valid) begin
                case (state)
                    IDLE: begin
                        state <= IDLE;
                    end
                    START: begin
                        start_bad <= sampled_bit;
                        state     <= DATA;
                    end
                    DATA: begin
                        // LSB arrives first, so after DATA_WIDTH right shifts it sits at bit 0.
                        data_sh <= {sampled_bit, data_sh[DATA_WIDTH-1:1]};
                        acc     <= acc ^ sampled_bit;
                        idx     <= idx + IDX_W'(1);
                        if (idx == IDX_W'(DATA_WIDTH - 1)) begin
                            state <= par_en_q ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_bad <= (acc ^ sampled_bit) != par_odd_q;
                        state   <= STOP;
                    end
                    STOP: begin
                        if (!two_stop_q || stop_idx) begin
                            state      <= IDLE;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            data_out   <= data_sh;
                            start_err  <= start_bad;
                            par_err    <= par_en_q & par_bad;
                            stop_err   <= stop_bad | ~sampled_bit;
                        end else begin
                            stop_idx <= 1'b1;
                            stop_bad <= stop_bad | ~sampled_bit;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Counters act on the registered frame_done pulse, so clr_cnt in that cycle wins.
    always_ff @(posedge clk) begin
        if (!rst || clr_cnt) begin
            start_err_cnt <= '0;
            par_err_cnt   <= '0;
            stop_err_cnt  <= '0;
        end else if (frame_done) begin
            if (start_err && (start_err_cnt != '1)) start_err_cnt <= start_err_cnt + CNT_WIDTH'(1);
            if (par_err && (par_err_cnt != '1))     par_err_cnt   <= par_err_cnt + CNT_WIDTH'(1);
            if (stop_err && (stop_err_cnt != '1))   stop_err_cnt  <= stop_err_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
